// File: rtl/fht_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : fht_butterfly
//  Description : Radix-2 Fast Hartley Transform butterfly. Rotates the pair
//                (x1, x2) by the twiddle (cos, sin), adds/subtracts the result
//                to/from x0, halves each output with round-half-up and
//                saturates to the data width. One-cycle registered latency,
//                one result per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module fht_butterfly #(
  parameter int D_BIT  = 17,
  parameter int W_BIT  = 12,
  parameter int W_HALF = 512
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic signed [W_BIT-1:0] iCOS,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1
);

  // Twiddle unity is 2*W_HALF, so the product is rescaled by log2 of that.
  localparam int C_WS    = $clog2(2 * W_HALF);
  // Full-precision widths: rotated sum, rescaled term, and add/sub result
  // (one guard bit above the wider of x0 and t).
  localparam int C_P_BIT = D_BIT + W_BIT + 1;
  localparam int C_T_BIT = C_P_BIT - C_WS;
  localparam int C_S_BIT = ((C_T_BIT > D_BIT) ? C_T_BIT : D_BIT) + 1;

  // Output clamp limits expressed at the add/sub width.
  localparam logic signed [C_S_BIT-1:0] C_Y_MAX = C_S_BIT'((2 ** (D_BIT - 1)) - 1);
  localparam logic signed [C_S_BIT-1:0] C_Y_MIN = ~C_Y_MAX;

  logic signed [C_P_BIT-1:0] w_prod_c;
  logic signed [C_P_BIT-1:0] w_prod_s;
  logic signed [C_P_BIT-1:0] w_p;
  logic signed [C_P_BIT-1:0] w_p_rnd;
  logic signed [C_P_BIT-1:0] w_p_shift;
  logic signed [C_T_BIT-1:0] w_t;
  logic signed [C_S_BIT-1:0] w_s0;
  logic signed [C_S_BIT-1:0] w_s1;
  logic signed [C_S_BIT-1:0] w_h0;
  logic signed [C_S_BIT-1:0] w_h1;
  logic signed [D_BIT-1:0]   w_y0;
  logic signed [D_BIT-1:0]   w_y1;

  logic signed [D_BIT-1:0]   r_y0;
  logic signed [D_BIT-1:0]   r_y1;

  // Clamp a halved sum/difference into the signed data range.
  function automatic logic signed [D_BIT-1:0] sat(input logic signed [C_S_BIT-1:0] v);
    if (v > C_Y_MAX) begin
      sat = D_BIT'(C_Y_MAX);
    end else if (v < C_Y_MIN) begin
      sat = D_BIT'(C_Y_MIN);
    end else begin
      sat = D_BIT'(v);
    end
  endfunction

  // Rotation, rescale with round-half-up, add/sub, halve and saturate.
  always_comb begin
    // Operands are sign-extended to the product width before multiplying so
    // no partial result is ever truncated.
    w_prod_c  = C_P_BIT'(iX_1) * C_P_BIT'(iCOS);
    w_prod_s  = C_P_BIT'(iX_2) * C_P_BIT'(iSIN);
    w_p       = w_prod_c + w_prod_s;
    w_p_rnd   = w_p + C_P_BIT'(W_HALF);
    w_p_shift = w_p_rnd >>> C_WS;
    w_t       = C_T_BIT'(w_p_shift);
    w_s0      = C_S_BIT'(iX_0) + C_S_BIT'(w_t);
    w_s1      = C_S_BIT'(iX_0) - C_S_BIT'(w_t);
    w_h0      = (w_s0 + C_S_BIT'(1)) >>> 1;
    w_h1      = (w_s1 + C_S_BIT'(1)) >>> 1;
    w_y0      = sat(w_h0);
    w_y1      = sat(w_h1);
  end

  // Output register with synchronous active-low clear.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      r_y0 <= '0;
      r_y1 <= '0;
    end else begin
      r_y0 <= w_y0;
      r_y1 <= w_y1;
    end
  end

  assign oY_0 = r_y0;
  assign oY_1 = r_y1;

endmodule
`default_nettype wire

// File: tb/tb_fht_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fht_butterfly
//  Description : Directed and streaming checks for the FHT butterfly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_butterfly;

  logic               clk;
  logic               rst_n;
  logic signed [16:0] x0, x1, x2;
  logic signed [11:0] sn, cs;
  logic signed [16:0] y0, y1;

  int total;
  int bad;

  fht_butterfly #(
    .D_BIT (17),
    .W_BIT (12),
    .W_HALF(512)
  ) dut (
    .iCLK  (clk),
    .iRESET(rst_n),
    .iX_0  (x0),
    .iX_1  (x1),
    .iX_2  (x2),
    .iSIN  (sn),
    .iCOS  (cs),
    .oY_0  (y0),
    .oY_1  (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input set at the falling edge (no checking here).
  task automatic drive(input int a0, input int a1, input int a2, input int c, input int s);
    @(negedge clk);
    x0 = 17'(a0);
    x1 = 17'(a1);
    x2 = 17'(a2);
    cs = 12'(c);
    sn = 12'(s);
  endtask

  // Reference: full-precision formula evaluated in 64-bit integers.
  task automatic model(input longint a0, input longint a1, input longint a2,
                       input longint c, input longint s,
                       output longint e0, output longint e1);
    longint p, t, s0, s1;
    p  = a1 * c + a2 * s;
    t  = (p + 512) >>> 10;
    s0 = a0 + t;
    s1 = a0 - t;
    e0 = (s0 + 1) >>> 1;
    e1 = (s1 + 1) >>> 1;
    if (e0 > 65535) e0 = 65535;
    if (e0 < -65536) e0 = -65536;
    if (e1 > 65535) e1 = 65535;
    if (e1 < -65536) e1 = -65536;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1234, 2000, -700, 1024, 300);
    @(negedge clk);
    total++;
    if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
      bad++;
      $display("FAIL reset_cycle1 got y0=%0d y1=%0d want 0 0", y0, y1);
    end
    @(negedge clk);
    total++;
    if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
      bad++;
      $display("FAIL reset_cycle2 got y0=%0d y1=%0d want 0 0", y0, y1);
    end
    rst_n = 1'b1;
    x0 = 17'sd100; x1 = 17'sd0; x2 = 17'sd0; cs = 12'sd0; sn = 12'sd0;
    @(negedge clk);
    total++;
    if (y0 !== 17'sd50 || y1 !== 17'sd50) begin
      bad++;
      $display("FAIL reset_release got y0=%0d y1=%0d want 50 50", y0, y1);
    end
  endtask

  task automatic test_zero_angle;
    drive(1000, 2000, 500, 1024, 0);
    @(negedge clk);
    total++;
    if (y0 !== 17'sd1500) begin
      bad++;
      $display("FAIL zero_angle_y0 got=%0d want=1500", y0);
    end
    total++;
    if (y1 !== 17'(-500)) begin
      bad++;
      $display("FAIL zero_angle_y1 got=%0d want=-500", y1);
    end
  endtask

  task automatic test_ninety;
    drive(0, 7, -300, 0, 1024);
    @(negedge clk);
    total++;
    if (y0 !== 17'(-150)) begin
      bad++;
      $display("FAIL ninety_y0 got=%0d want=-150", y0);
    end
    total++;
    if (y1 !== 17'sd150) begin
      bad++;
      $display("FAIL ninety_y1 got=%0d want=150", y1);
    end
  endtask

  task automatic test_fortyfive;
    drive(0, 10000, 10000, 724, 724);
    @(negedge clk);
    total++;
    if (y0 !== 17'sd7071) begin
      bad++;
      $display("FAIL fortyfive_y0 got=%0d want=7071", y0);
    end
    total++;
    if (y1 !== 17'(-7070)) begin
      bad++;
      $display("FAIL fortyfive_y1 got=%0d want=-7070", y1);
    end
  endtask

  // Halving rounds half up: -3 -> -1 on both outputs when t = 0.
  task automatic test_round;
    drive(-3, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (y0 !== 17'(-1) || y1 !== 17'(-1)) begin
      bad++;
      $display("FAIL round_half got y0=%0d y1=%0d want -1 -1", y0, y1);
    end
  endtask

  task automatic test_saturation;
    drive(65535, 65535, 65535, 2047, 2047);
    @(negedge clk);
    total++;
    if (y0 !== 17'sd65535) begin
      bad++;
      $display("FAIL sat_y0 got=%0d want=65535", y0);
    end
    total++;
    if (y1 !== 17'(-65536)) begin
      bad++;
      $display("FAIL sat_y1 got=%0d want=-65536", y1);
    end
  endtask

  // Most-negative data and coefficients: p = 2^28, t = 262144.
  task automatic test_coef_min;
    drive(-65536, -65536, -65536, -2048, -2048);
    @(negedge clk);
    total++;
    if (y0 !== 17'sd65535) begin
      bad++;
      $display("FAIL coef_min_y0 got=%0d want=65535", y0);
    end
    total++;
    if (y1 !== 17'(-65536)) begin
      bad++;
      $display("FAIL coef_min_y1 got=%0d want=-65536", y1);
    end
  endtask

  task automatic test_back_to_back;
    longint e0, e1, p0, p1;
    int a0, a1, a2, c, s;
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (y0 !== 17'(p0) || y1 !== 17'(p1)) begin
          bad++;
          $display("FAIL stream[%0d] got y0=%0d y1=%0d want %0d %0d", i - 1, y0, y1, p0, p1);
        end
      end
      if (i < 30) begin
        a0 = int'($urandom_range(65534)) - 32767;
        a1 = int'($urandom_range(65534)) - 32767;
        a2 = int'($urandom_range(65534)) - 32767;
        c  = int'($urandom_range(2048)) - 1024;
        s  = int'($urandom_range(2048)) - 1024;
        x0 = 17'(a0);
        x1 = 17'(a1);
        x2 = 17'(a2);
        cs = 12'(c);
        sn = 12'(s);
        rst_n = (i == 15) ? 1'b0 : 1'b1;
        model(longint'(a0), longint'(a1), longint'(a2), longint'(c), longint'(s), e0, e1);
        p0 = (i == 15) ? 0 : e0;
        p1 = (i == 15) ? 0 : e1;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; cs = '0; sn = '0;
    test_reset();
    test_zero_angle();
    test_ninety();
    test_fortyfive();
    test_round();
    test_saturation();
    test_coef_min();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fht_butterfly.md
Name: fht_butterfly

Overview:
- Radix-2 butterfly for the Fast Hartley Transform datapath.
- Combines a direct sample x0 with a rotated pair (x1, x2) using a twiddle pair (cos, sin), and produces the sum and difference outputs.
- Outputs are scaled by 1/2 per stage to contain growth.
- Fully pipelined: accepts one input set per clock; outputs are registered.

Parameters:
- D_BIT, 17: width of signed data inputs/outputs.
- W_BIT, 12: width of signed twiddle coefficients; unity gain = 2*W_HALF.
- W_HALF, 512: half of the twiddle unity value (unity = 1024). Used as the rounding constant. Shift amount WS = log2(2*W_HALF) = 10, derived as a localparam.

Ports:
- iCLK  in  1  clock, all logic on rising edge
- iRESET  in  1  synchronous, active-low reset
- iX_0  in  D_BIT signed  direct sample x0
- iX_1  in  D_BIT signed  sample x1 (multiplied by cos)
- iX_2  in  D_BIT signed  mirrored sample x2 (multiplied by sin)
- iSIN  in  W_BIT signed  sine twiddle, scaled by 2*W_HALF
- iCOS  in  W_BIT signed  cosine twiddle, scaled by 2*W_HALF
- oY_0  out  D_BIT signed  sum output
- oY_1  out  D_BIT signed  difference output

Behaviour:
- Clocking and reset: single clock iCLK. Reset is synchronous, active-low on iRESET. While iRESET=0 at a rising edge, oY_0 and oY_1 become 0.
- Arithmetic, full precision, no intermediate truncation:
  - p = x1*cos + x2*sin, width D_BIT+W_BIT+1.
  - t = (p + W_HALF) >>> WS. Round half up; arithmetic shift, i.e. floor.
  - s0 = x0 + t; s1 = x0 - t.
  - y0 = (s0 + 1) >>> 1; y1 = (s1 + 1) >>> 1. Round half up.
- Output saturation: y0 and y1 are saturated to the signed D_BIT range [-2^(D_BIT-1), 2^(D_BIT-1)-1] before registering. No wrap-around.
- Latency: exactly 1 clock. Inputs sampled at rising edge N appear on oY_0/oY_1 immediately after edge N.
- Throughput: one result per clock. No handshake and no enable; inputs are sampled every cycle.
- Reset mid-stream: the output register is cleared on that edge. The first valid result appears on the edge after iRESET returns to 1.
- Coefficient range: cos/sin of ±(2*W_HALF) must be representable, which requires W_BIT ≥ WS+2. The magnitude maximum -2^(W_BIT-1) is accepted and computed without special handling.
- Implementation: signed multipliers, rounding adders, saturation, and an output register only. No state machine.

Test Plan:
- Reset: drive iRESET=0 for 2 clocks with nonzero inputs -> oY_0=oY_1=0. Release reset -> outputs follow the inputs after 1 clock.
- Zero angle: x0=1000, x1=2000, x2=500, cos=1024, sin=0 -> t=2000, oY_0=1500, oY_1=-500.
- 90°: x0=0, x1=7, x2=-300, cos=0, sin=1024 -> t=-300, oY_0=-150, oY_1=150.
- 45°: x0=0, x1=x2=10000, cos=sin=724 -> p=14480000, t=14141, oY_0=7071, oY_1=-7070.
- Saturation: x0=x1=x2=65535, cos=sin=2047 -> t=262012, oY_0=65535 (clamped from 163774), oY_1=-65536 (clamped from -98238).
- Streaming: apply 30 random sets (|x| ≤ 32767, |cos|,|sin| ≤ 1024) on consecutive clocks. Each output pair must match the formula for inputs from the previous edge. Assert reset once mid-stream -> that cycle's outputs are 0.
